// File: rtl/sar_search_controller_if.sv
// Handshake and comparator bundle for sar_search_controller.
// The slave modport is the search engine. The master modport is the requester/comparator side.
interface sar_search_controller_if #(
  parameter int WIDTH = 4,
  parameter int STEPW = $clog2(WIDTH + 1)
);
  logic             start;
  logic             less;
  logic             greater;
  logic             equal;
  logic [WIDTH-1:0] probe;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] value;
  logic             exact;
  logic             err;
  logic [STEPW-1:0] steps;

  modport master (
    output start, less, greater, equal,
    input  probe, busy, done, value, exact, err, steps
  );

  modport slave (
    input  start, less, greater, equal,
    output probe, busy, done, value, exact, err, steps
  );
endinterface

// File: rtl/sar_search_controller.sv
// MSB-first successive-approximation search.
// It drives a comparator's b operand and reads back less/greater/equal.
module sar_search_controller #(
  parameter int WIDTH = 4,
  parameter int STEPW = $clog2(WIDTH + 1)
) (
  input logic                    clk,
  input logic                    rst_n,
  sar_search_controller_if.slave bus
);
  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [IDXW-1:0]  IDX_TOP = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             exact_q, exact_d;
  logic             err_q, err_d;
  logic [STEPW-1:0] steps_q, steps_d;
  logic [WIDTH-1:0] acc_next;
  logic [2:0]       resp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= IDX_TOP;
      acc_q   <= '0;
      probe_q <= '0;
      value_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      exact_q <= 1'b0;
      err_q   <= 1'b0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      probe_q <= probe_d;
      value_q <= value_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      exact_q <= exact_d;
      err_q   <= err_d;
      steps_q <= steps_d;
    end
  end

  // busy and done are computed one state ahead so both leave the block registered.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    probe_d  = probe_q;
    value_d  = value_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    exact_d  = exact_q;
    err_d    = err_q;
    steps_d  = steps_q;
    acc_next = acc_q;
    resp     = {bus.less, bus.greater, bus.equal};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          idx_d   = IDX_TOP;
          probe_d = ONE << (WIDTH - 1);
          steps_d = '0;
          exact_d = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = PROBE;
        end
      end
      PROBE: begin
        steps_d = steps_q + STEPW'(1);
        case (resp)
          3'b001: begin
            value_d = probe_q;
            exact_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
          3'b010, 3'b100: begin
            acc_next = resp[1] ? probe_q : acc_q;
            if (idx_q == '0) begin
              value_d = acc_next;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              acc_d   = acc_next;
              idx_d   = idx_q - IDXW'(1);
              probe_d = acc_next | (ONE << (idx_q - IDXW'(1)));
            end
          end
          default: begin
            err_d   = 1'b1;
            value_d = acc_q;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        endcase
      end
      DONE: begin
        probe_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.probe = probe_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.value = value_q;
  assign bus.exact = exact_q;
  assign bus.err   = err_q;
  assign bus.steps = steps_q;
endmodule

// File: tb/tb_sar_search_controller.sv
// Scoreboard bench for sar_search_controller.
// A behavioural comparator answers each probe, and expected results are queued at start and checked at done.
module tb_sar_search_controller;
  localparam int W  = 4;
  localparam int SW = $clog2(W + 1);

  typedef struct {
    logic [W-1:0]  value;
    logic          exact;
    logic          err;
    logic [SW-1:0] steps;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sar_search_controller_if #(.WIDTH(W), .STEPW(SW)) bus ();
  sar_search_controller #(.WIDTH(W), .STEPW(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [W-1:0] target = '0;
  logic         force_bad = 1'b0;
  logic [W-1:0] held_value = '0;
  res_t         sb[$];
  logic [W-1:0] pq[$];
  int           vectors = 0;
  int           miscompares = 0;

  always_comb begin
    bus.less    = target < bus.probe;
    bus.greater = target > bus.probe;
    bus.equal   = target == bus.probe;
    if (force_bad) begin
      bus.less    = 1'b1;
      bus.greater = 1'b1;
      bus.equal   = 1'b0;
    end
  end

  task automatic model(input logic [W-1:0] t, input int bad_step);
    res_t r;
    logic [W-1:0] acc, p, one;
    one = 1;
    acc = '0;
    r.value = '0; r.exact = 1'b0; r.err = 1'b0; r.steps = '0;
    for (int i = W - 1; i >= 0; i--) begin
      p = acc | (one << i);
      pq.push_back(p);
      r.steps = r.steps + 1'b1;
      if (int'(r.steps) == bad_step) begin
        r.err = 1'b1;
        break;
      end
      if (t == p) begin
        acc = p;
        r.exact = 1'b1;
        break;
      end
      if (t > p) acc = p;
    end
    r.value = acc;
    sb.push_back(r);
  endtask

  task automatic check_idle_outputs(input string tag);
    vectors++;
    if (bus.probe !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.value !== '0 ||
        bus.exact !== 1'b0 || bus.err !== 1'b0 || bus.steps !== '0) begin
      miscompares++;
      $display("FAIL %s: probe=%0d busy=%b done=%b value=%0d exact=%b err=%b steps=%0d, want all zero",
               tag, bus.probe, bus.busy, bus.done, bus.value, bus.exact, bus.err, bus.steps);
    end
  endtask

  task automatic run_search(input logic [W-1:0] t, input int bad_step, input bit poke_start);
    res_t exp;
    logic [W-1:0] ep;
    int edges, pcnt;
    pq.delete();
    target = t;
    model(t, bad_step);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    edges = 0;
    pcnt = 1;
    while (bus.done !== 1'b1 && edges < 20) begin
      vectors++;
      if (bus.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL busy t=%0d step=%0d: got %b want 1", t, pcnt, bus.busy);
      end
      ep = (pq.size() > 0) ? pq.pop_front() : 'x;
      vectors++;
      if (bus.probe !== ep) begin
        miscompares++;
        $display("FAIL probe t=%0d step=%0d: got %0d want %0d", t, pcnt, bus.probe, ep);
      end
      vectors++;
      if (bus.value !== held_value) begin
        miscompares++;
        $display("FAIL value_hold t=%0d: got %0d want %0d", t, bus.value, held_value);
      end
      force_bad = (pcnt == bad_step);
      if (poke_start && pcnt == 2) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      force_bad = 1'b0;
      edges++;
      pcnt++;
    end
    exp = sb.pop_front();
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_timeout t=%0d: done=%b after %0d edges", t, bus.done, edges);
      return;
    end
    vectors++;
    if (bus.value !== exp.value || bus.exact !== exp.exact || bus.err !== exp.err ||
        bus.steps !== exp.steps || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL result t=%0d: value=%0d exact=%b err=%b steps=%0d busy=%b, want value=%0d exact=%b err=%b steps=%0d busy=0",
               t, bus.value, bus.exact, bus.err, bus.steps, bus.busy,
               exp.value, exp.exact, exp.err, exp.steps);
    end
    // done rises on the edge that ends the final probe: steps edges after the start edge
    vectors++;
    if (edges != int'(exp.steps)) begin
      miscompares++;
      $display("FAIL latency t=%0d: done after %0d edges, want %0d", t, edges, exp.steps);
    end
    held_value = exp.value;
    if (poke_start) bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.probe !== '0 || bus.value !== exp.value ||
        bus.steps !== exp.steps) begin
      miscompares++;
      $display("FAIL after_done t=%0d: done=%b busy=%b probe=%0d value=%0d steps=%0d, want 0 0 0 %0d %0d",
               t, bus.done, bus.busy, bus.probe, bus.value, bus.steps, exp.value, exp.steps);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("idle_no_start");
  endtask

  task automatic test_exact_hit();
    run_search(4'd11, 0, 1'b0);
    run_search(4'd8, 0, 1'b0);
  endtask

  task automatic test_boundaries();
    run_search(4'd0, 0, 1'b0);
    run_search(4'd15, 0, 1'b0);
  endtask

  task automatic test_bad_response();
    run_search(4'd11, 2, 1'b0);
    run_search(4'd3, 1, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_search(4'd13, 0, 1'b1);
    run_search(4'd6, 0, 1'b0);
  endtask

  task automatic test_reset_mid_search();
    target = 4'd5;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.probe !== 4'd6 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL third_probe: probe=%0d busy=%b, want 6 1", bus.probe, bus.busy);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("reset_mid");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("no_done_after_reset");
    held_value = '0;
    run_search(4'd5, 0, 1'b0);
  endtask

  task automatic test_sweep();
    for (int t = 0; t < (1 << W); t++) run_search(W'(t), 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) run_search(W'($urandom_range(0, (1 << W) - 1)), 0, k[0]);
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_exact_hit();
    test_boundaries();
    test_bad_response();
    test_start_ignored();
    test_reset_mid_search();
    test_sweep();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
